// File: rtl/apb_rr_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_rr_master_pkg
//   Shared types and helpers for the round-robin APB master.
//   - state_t : APB master phase (IDLE / SETUP / ACCESS)
//   - idx_w   : width of an index able to address n items, never below 1
// ---------------------------------------------------------------------------
package apb_rr_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_master_pick.sv
// ---------------------------------------------------------------------------
// apb_rr_pick
//   Combinational round-robin picker. Searches from i_last+1 upward, wrapping
//   modulo NREQ, and returns the first eligible requester.
// Ports:
//   i_elig  [NREQ]  eligible requesters
//   i_last  [IW]    index granted most recently
//   o_any           at least one requester is eligible
//   o_win   [IW]    winning index (0 when o_any is low)
// ---------------------------------------------------------------------------
module apb_rr_pick
    import apb_rr_master_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_last,
    output logic            o_any,
    output logic [IW-1:0]   o_win
);

    logic [IW-1:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest eligible
    // requester after i_last is the one left in o_win.
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        w_idx = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_idx = IW'((int'(i_last) + off) % NREQ);
            if (i_elig[w_idx]) begin
                o_any = 1'b1;
                o_win = w_idx;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//   Shares one APB master port among NREQ local requesters. Arbitrates
//   round-robin, runs the SETUP/ACCESS sequence, holds through wait states
//   and returns read data / error to the winner. With TIMEOUT>0 an ACCESS
//   phase that sees PREADY low for TIMEOUT cycles is ended with an error.
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   req_valid/write [NREQ]  per-requester request and direction
//   req_addr/wdata/strb/prot packed per-requester fields (i*W +: W)
//   req_done [NREQ]         one-hot, one-cycle completion pulse
//   rsp_rdata [DW]          read data, held until the next completion
//   rsp_err                 PSLVERR or timeout, valid with req_done
//   timeout_evt             pulse when a transfer is ended by timeout
//   PADDR..PENABLE          registered APB master outputs
//   PREADY, PRDATA, PSLVERR APB slave response
// ---------------------------------------------------------------------------
module apb_rr_master
    import apb_rr_master_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*(DW/8)-1:0] req_strb,
    input  logic [NREQ*3-1:0]      req_prot,
    output logic [NREQ-1:0]        req_done,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   rsp_err,
    output logic                   timeout_evt,
    output logic [AW-1:0]          PADDR,
    output logic                   PWRITE,
    output logic [DW-1:0]          PWDATA,
    output logic [DW/8-1:0]        PSTRB,
    output logic [2:0]             PPROT,
    output logic                   PSEL,
    output logic                   PENABLE,
    input  logic                   PREADY,
    input  logic [DW-1:0]          PRDATA,
    input  logic                   PSLVERR
);

    localparam int IW = idx_w(NREQ);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CMAX = '1;
    // The counter holds the number of wait cycles already seen; when it sits
    // at TIMEOUT-1 with PREADY low, this cycle would make it reach TIMEOUT.
    localparam logic [CW-1:0] TLIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_grant;
    logic [CW-1:0]   r_wcnt;
    logic [NREQ-1:0] w_elig;
    logic            w_any;
    logic [IW-1:0]   w_win;
    logic            w_load;
    logic            w_cmpl;
    logic            w_tmo;

    // A requester whose completion pulse is out this cycle still shows
    // req_valid; masking it stops an immediate re-grant of the same job.
    assign w_elig = req_valid & ~req_done;

    apb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_elig (w_elig),
        .i_last (r_last),
        .o_any  (w_any),
        .o_win  (w_win)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cmpl      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                // PREADY has priority over a timeout landing in the same cycle.
                if (PREADY) begin
                    w_cmpl      = 1'b1;
                    w_state_nxt = IDLE;
                end else if ((TIMEOUT > 0) && (r_wcnt == TLIM)) begin
                    w_cmpl      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_last      <= IW'(NREQ - 1);
            r_grant     <= '0;
            r_wcnt      <= '0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            req_done    <= w_cmpl ? (NREQ'(1) << r_grant) : '0;
            rsp_err     <= w_cmpl & (w_tmo | PSLVERR);
            timeout_evt <= w_tmo;

            // Transfer fields are captured only here, so they stay stable
            // through SETUP and ACCESS regardless of the requester inputs.
            if (w_load) begin
                PADDR   <= req_addr [int'(w_win)*AW +: AW];
                PWRITE  <= req_write[w_win];
                PWDATA  <= req_wdata[int'(w_win)*DW +: DW];
                PSTRB   <= req_strb [int'(w_win)*SW +: SW];
                PPROT   <= req_prot [int'(w_win)*3  +: 3];
                PSEL    <= 1'b1;
                r_grant <= w_win;
                r_last  <= w_win;
            end

            if (r_state == SETUP) begin
                PENABLE <= 1'b1;
                r_wcnt  <= '0;
            end

            if ((r_state == ACCESS) && !PREADY && (r_wcnt != CMAX))
                r_wcnt <= r_wcnt + 1'b1;

            if (w_cmpl) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                if (w_tmo)        rsp_rdata <= '0;
                else if (!PWRITE) rsp_rdata <= PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 8;

    logic                   PCLK = 1'b0;
    logic                   PRESET;
    logic [NREQ-1:0]        req_valid, req_write, req_done;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*DW-1:0]     req_wdata;
    logic [NREQ*(DW/8)-1:0] req_strb;
    logic [NREQ*3-1:0]      req_prot;
    logic [DW-1:0]          rsp_rdata, PWDATA, PRDATA;
    logic                   rsp_err, timeout_evt, PWRITE, PSEL, PENABLE;
    logic                   PREADY, PSLVERR;
    logic [AW-1:0]          PADDR;
    logic [DW/8-1:0]        PSTRB;
    logic [2:0]             PPROT;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .timeout_evt(timeout_evt),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    endtask

    // Slave address encoding: [11:8] wait cycles, [12] PSLVERR, [13] never ready.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] wd_of(input int i, input int n);
        return {8'(i), 8'(n), 16'hC0DE};
    endfunction

    // ------------------------------------------------ requester side
    int          posted[NREQ];
    int          served[NREQ];
    int          sofs[NREQ];
    logic [31:0] base[NREQ];
    logic        wrm[NREQ];

    always_comb begin
        req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0;  req_prot = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = (posted[i] != served[i]);
            req_write[i]          = wrm[i];
            req_addr[i*AW +: AW]  = base[i] + 32'((served[i] - sofs[i]) * 4);
            req_wdata[i*DW +: DW] = wd_of(i, served[i]);
            req_strb[i*4 +: 4]    = 4'(i + 1);
            req_prot[i*3 +: 3]    = 3'(i + 1);
        end
    end

    // ------------------------------------------------ slave model
    int acnt;
    always @(negedge PCLK) begin
        if (!PRESET && PSEL && PENABLE) begin
            PREADY  = !PADDR[13] && (acnt == int'(PADDR[11:8]));
            PRDATA  = rd_of(PADDR);
            PSLVERR = PADDR[12];
            acnt++;
        end else begin
            PREADY  = 1'b1;   // must be ignored outside ACCESS
            PRDATA  = 32'hBAD0BAD0;
            PSLVERR = 1'b1;
            acnt    = 0;
        end
    end

    // ------------------------------------------------ scoreboard
    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        err, tmo;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   m_last;
    int   m_rem[NREQ], m_n[NREQ], m_st[NREQ];

    task automatic post(input int i, input logic [31:0] b, input logic w, input int cnt);
        base[i] = b; wrm[i] = w; sofs[i] = served[i];
        posted[i] = served[i] + cnt;
        m_rem[i] = cnt; m_n[i] = served[i]; m_st[i] = served[i];
    endtask

    // Round-robin reference: push expected completions in grant order.
    task automatic model();
        for (int k = 0; k < 64; k++) begin
            int   f, w;
            exp_t e;
            f = -1;
            for (int off = 1; off <= NREQ; off++)
                if (f < 0 && m_rem[(m_last + off) % NREQ] > 0) f = (m_last + off) % NREQ;
            if (f < 0) break;
            e.idx   = f;
            e.wr    = wrm[f];
            e.addr  = base[f] + 32'((m_n[f] - m_st[f]) * 4);
            e.wdata = wd_of(f, m_n[f]);
            e.strb  = 4'(f + 1);
            e.prot  = 3'(f + 1);
            w       = int'(e.addr[11:8]);
            e.tmo   = e.addr[13] || (w >= TMO);
            e.acc   = e.tmo ? TMO : w + 1;
            e.err   = e.tmo ? 1'b1 : e.addr[12];
            e.rdata = rd_of(e.addr);
            q.push_back(e);
            m_last = f; m_rem[f]--; m_n[f]++;
        end
    endtask

    logic [31:0] hold, s_addr, s_wd;
    logic [3:0]  s_strb;
    logic [2:0]  s_prot;
    logic        s_wr;
    int          acc;

    always @(negedge PCLK) begin
        if (PRESET) begin
            hold = '0;
        end else begin
            if (PSEL && !PENABLE) begin
                if (q.size() == 0) chk("unexp_grant", 32'd1, 32'd0);
                else begin
                    chk("paddr",  PADDR,  q[0].addr);
                    chk("pwrite", PWRITE, q[0].wr);
                    chk("pwdata", PWDATA, q[0].wdata);
                    chk("pstrb",  PSTRB,  q[0].strb);
                    chk("pprot",  PPROT,  q[0].prot);
                end
                s_addr = PADDR; s_wd = PWDATA; s_strb = PSTRB; s_prot = PPROT; s_wr = PWRITE;
                acc = 0;
            end else if (PSEL && PENABLE) begin
                acc++;
                chk("hold_addr",  PADDR,  s_addr);
                chk("hold_wdata", PWDATA, s_wd);
                chk("hold_strb",  PSTRB,  s_strb);
                chk("hold_prot",  PPROT,  s_prot);
                chk("hold_write", PWRITE, s_wr);
            end
            if (req_done != '0) begin
                if (q.size() == 0) chk("unexp_done", 32'(req_done), 32'd0);
                else begin
                    exp_t        e;
                    logic [31:0] er;
                    e  = q.pop_front();
                    er = e.tmo ? 32'd0 : (e.wr ? hold : e.rdata);
                    chk("done_vec", 32'(req_done), 32'(1 << e.idx));
                    chk("rsp_err",  rsp_err,       e.err);
                    chk("tevt",     timeout_evt,   e.tmo);
                    chk("rdata",    rsp_rdata,     er);
                    chk("acc_cyc",  acc,           e.acc);
                    chk("psel_off", PSEL,          1'b0);
                    hold = er;
                    served[e.idx]++;
                end
            end else begin
                chk("err_idle",  rsp_err,     1'b0);
                chk("tevt_idle", timeout_evt, 1'b0);
            end
        end
    end

    task automatic drain(input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge PCLK);
            ok = (q.size() == 0);
            for (int i = 0; i < NREQ; i++) if (posted[i] != served[i]) ok = 0;
        end
        chk("drain", 32'(ok), 32'd1);
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            posted[i] = 0; served[i] = 0; sofs[i] = 0; base[i] = '0; wrm[i] = 1'b0;
            m_rem[i] = 0; m_n[i] = 0; m_st[i] = 0;
        end
        m_last = NREQ - 1;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("rst_psel",  PSEL,        1'b0);
        chk("rst_pen",   PENABLE,     1'b0);
        chk("rst_done",  32'(req_done), 32'd0);
        chk("rst_rdata", rsp_rdata,   32'd0);
        chk("rst_err",   rsp_err,     1'b0);
        chk("rst_tevt",  timeout_evt, 1'b0);
        chk("rst_paddr", PADDR,       32'd0);

        // Contention: all four valid from reset, two jobs each.
        for (int i = 0; i < NREQ; i++) post(i, 32'(i + 1) << 16, 1'(i), 2);
        model();
        @(negedge PCLK) PRESET = 1'b0;
        drain(200);

        // Single zero-wait read with edge-accurate timing.
        post(2, 32'h40, 1'b0, 1);
        model();
        @(posedge PCLK) #1;
        chk("rd_k_psel", PSEL, 1'b1);
        chk("rd_k_pen",  PENABLE, 1'b0);
        @(posedge PCLK) #1;
        chk("rd_k1_pen", PENABLE, 1'b1);
        @(posedge PCLK) #1;
        chk("rd_k2_done",  32'(req_done), 32'h4);
        chk("rd_k2_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_k2_err",   rsp_err, 1'b0);
        drain(50);

        // Five wait states on a write.
        post(1, 32'h0001_0500, 1'b1, 1);
        model();
        drain(50);

        // Slave error, then a normal write.
        post(3, 32'h0003_1000, 1'b0, 1);
        post(0, 32'h0004_0200, 1'b1, 1);
        model();
        drain(60);

        // PREADY on the timeout cycle, never-ready read, over-long write.
        post(1, 32'h0006_0700, 1'b0, 1);
        post(2, 32'h0005_2000, 1'b0, 1);
        post(3, 32'h0007_0900, 1'b1, 1);
        model();
        drain(120);

        // Reset in the middle of a wait state.
        post(2, 32'h0008_0600, 1'b0, 1);
        model();
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge PCLK);
                seen = PSEL && PENABLE;
            end
            chk("rst_mid_reach", 32'(seen), 32'd1);
        end
        repeat (2) @(negedge PCLK);
        post(0, 32'h0009_0000, 1'b0, 1);
        #2 PRESET = 1'b1;
        #1;
        chk("arst_psel", PSEL,    1'b0);
        chk("arst_pen",  PENABLE, 1'b0);
        chk("arst_done", 32'(req_done), 32'd0);
        q.delete();
        for (int i = 0; i < NREQ; i++) begin
            m_rem[i] = posted[i] - served[i];
            m_n[i]   = served[i];
        end
        m_last = NREQ - 1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        model();
        drain(80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
